// File: rtl/row_request_scheduler_if.sv
// AXI-Stream row request channel between the scheduler (master) and the row-data consumer (slave).
interface row_request_scheduler_if;
  logic [31:0] AXIS_REQ_TDATA;
  logic        AXIS_REQ_TVALID;
  logic        AXIS_REQ_TREADY;

  modport master (
    output AXIS_REQ_TDATA,
    output AXIS_REQ_TVALID,
    input  AXIS_REQ_TREADY
  );

  modport slave (
    input  AXIS_REQ_TDATA,
    input  AXIS_REQ_TVALID,
    output AXIS_REQ_TREADY
  );
endinterface

// File: rtl/row_request_scheduler.sv
// Issues one row request per index for a dataset, bounded by an outstanding-row credit window.
// Optional inter-request pacing (GAP state, min_gap) is built only when ROW_PACING_EN is defined.
module row_request_scheduler #(
  parameter int MAX_OUTSTANDING = 16,
  parameter int CW              = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           abort,
  input  logic [31:0]                    first_row,
  input  logic [31:0]                    total_rows,
  input  logic [15:0]                    min_gap,
  input  logic                           row_complete,
  input  logic                           underflow,
  output logic                           row_requestor_idle,
  output logic [31:0]                    rows_requested,
  output logic [CW-1:0]                  outstanding,
  output logic [15:0]                    underflow_count,
  row_request_scheduler_if.master        req
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  state_t        state_q, state_d;
  logic [31:0]   first_row_q, first_row_d;
  logic [31:0]   total_rows_q, total_rows_d;
  logic [31:0]   rows_req_q, rows_req_d;
  logic [31:0]   tdata_q, tdata_d;
  logic [CW-1:0] outs_q, outs_d;
  logic [15:0]   uf_cnt_q, uf_cnt_d;
  logic          tvalid_q, tvalid_d;
  logic          idle_q, idle_d;
  logic          accept, hs, last_row, dec;

`ifdef ROW_PACING_EN
  logic [15:0]   gap_q, gap_d;
  logic [15:0]   gap_cnt_q, gap_cnt_d;
`else
  logic          unused_min_gap;
  assign unused_min_gap = ^min_gap;
`endif

  // abort masks every other event in its cycle, so all qualifiers include !abort
  assign accept   = (state_q == S_IDLE) && start && (total_rows != 32'd0) && !abort;
  assign hs       = tvalid_q && req.AXIS_REQ_TREADY && !abort;
  assign last_row = (rows_req_q + 32'd1) == total_rows_q;
  assign dec      = row_complete && (outs_q != '0) && !abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (accept) state_d = S_ISSUE;
        S_ISSUE: begin
          if (hs) begin
            if (last_row) state_d = S_IDLE;
`ifdef ROW_PACING_EN
            else if (gap_q != 16'd0) state_d = S_GAP;
`endif
          end
        end
`ifdef ROW_PACING_EN
        S_GAP:   if (gap_cnt_q <= 16'd1) state_d = S_ISSUE;
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    first_row_d  = first_row_q;
    total_rows_d = total_rows_q;
    rows_req_d   = rows_req_q;
    outs_d       = outs_q;
    uf_cnt_d     = uf_cnt_q;
    if (accept) begin
      first_row_d  = first_row;
      total_rows_d = total_rows;
      rows_req_d   = 32'd0;
      outs_d       = '0;
      uf_cnt_d     = 16'd0;
    end else if (!abort) begin
      if (hs) rows_req_d = rows_req_q + 32'd1;
      case ({hs, dec})
        2'b10:   outs_d = outs_q + 1'b1;
        2'b01:   outs_d = outs_q - 1'b1;
        default: outs_d = outs_q;
      endcase
      if (underflow && (uf_cnt_q != 16'hFFFF)) uf_cnt_d = uf_cnt_q + 16'd1;
    end
    // Outputs are registered from next-state values so they line up with the state they describe
    idle_d   = (state_d == S_IDLE);
    tvalid_d = (state_d == S_ISSUE) && (outs_d < MAX_CNT);
    tdata_d  = first_row_d + rows_req_d;
  end

`ifdef ROW_PACING_EN
  always_comb begin
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    if (accept) begin
      gap_d = min_gap;
    end else if (hs && !last_row) begin
      gap_cnt_d = gap_q;
    end else if ((state_q == S_GAP) && (gap_cnt_q != 16'd0)) begin
      gap_cnt_d = gap_cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_q     <= 16'd0;
      gap_cnt_q <= 16'd0;
    end else begin
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_row_q  <= 32'd0;
      total_rows_q <= 32'd0;
      rows_req_q   <= 32'd0;
      outs_q       <= '0;
      uf_cnt_q     <= 16'd0;
      tvalid_q     <= 1'b0;
      idle_q       <= 1'b1;
      tdata_q      <= 32'd0;
    end else begin
      first_row_q  <= first_row_d;
      total_rows_q <= total_rows_d;
      rows_req_q   <= rows_req_d;
      outs_q       <= outs_d;
      uf_cnt_q     <= uf_cnt_d;
      tvalid_q     <= tvalid_d;
      idle_q       <= idle_d;
      tdata_q      <= tdata_d;
    end
  end

  assign row_requestor_idle  = idle_q;
  assign rows_requested      = rows_req_q;
  assign outstanding         = outs_q;
  assign underflow_count     = uf_cnt_q;
  assign req.AXIS_REQ_TDATA  = tdata_q;
  assign req.AXIS_REQ_TVALID = tvalid_q;

endmodule

// File: tb/tb_row_request_scheduler.sv
// Directed bench for row_request_scheduler: scoreboard of expected row indices plus state/counter checks.
module tb_row_request_scheduler;
  localparam int MAXO = 4;
`ifdef ROW_PACING_EN
  localparam int EXP_GAP = 3;
`else
  localparam int EXP_GAP = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] first_row = 32'd0;
  logic [31:0] total_rows = 32'd0;
  logic [15:0] min_gap = 16'd0;
  logic        row_complete = 1'b0;
  logic        underflow = 1'b0;
  logic        idle;
  logic [31:0] rows_req;
  logic [7:0]  outs;
  logic [15:0] ufc;

  row_request_scheduler_if req_if ();

  row_request_scheduler #(.MAX_OUTSTANDING(MAXO), .CW(8)) u_dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .abort              (abort),
    .first_row          (first_row),
    .total_rows         (total_rows),
    .min_gap            (min_gap),
    .row_complete       (row_complete),
    .underflow          (underflow),
    .row_requestor_idle (idle),
    .rows_requested     (rows_req),
    .outstanding        (outs),
    .underflow_count    (ufc),
    .req                (req_if.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cnt = 0;
  logic [31:0] sb[$];
  int hs_cyc[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Handshake monitor: every accepted request must match the next expected row index
  always @(negedge clk) begin
    if (!reset && req_if.AXIS_REQ_TVALID && req_if.AXIS_REQ_TREADY) begin
      hs_cnt++;
      hs_cyc.push_back(cyc);
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_req: observed 0x%0h expected no request", req_if.AXIS_REQ_TDATA);
      end
      if (sb.size() != 0) chk("tdata", req_if.AXIS_REQ_TDATA, sb.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] f, input logic [31:0] t, input logic [15:0] g);
    first_row  = f;
    total_rows = t;
    min_gap    = g;
    start      = 1'b1;
    for (int i = 0; i < int'(t); i++) sb.push_back(f + 32'(i));
    hs_cnt = 0;
    hs_cyc.delete();
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (!idle && n < limit) begin
      tick(1);
      n++;
    end
    chk("idle_timeout", {31'd0, idle}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    req_if.AXIS_REQ_TREADY = 1'b1;
    tick(3);
    @(negedge clk);
    chk("rst_idle",   {31'd0, idle}, 32'd1);
    chk("rst_tvalid", {31'd0, req_if.AXIS_REQ_TVALID}, 32'd0);
    chk("rst_tdata",  req_if.AXIS_REQ_TDATA, 32'd0);
    chk("rst_rows",   rows_req, 32'd0);
    chk("rst_outs",   {24'd0, outs}, 32'd0);
    chk("rst_ufc",    {16'd0, ufc}, 32'd0);
    reset = 1'b0;
    tick(1);

    // Basic run: back-to-back requests 100..103 filling the credit window
    do_start(32'd100, 32'd4, 16'd0);
    @(negedge clk);
    chk("basic_idle",   {31'd0, idle}, 32'd0);
    chk("basic_tvalid", {31'd0, req_if.AXIS_REQ_TVALID}, 32'd1);
    chk("basic_tdata0", req_if.AXIS_REQ_TDATA, 32'd100);
    wait_idle(20);
    chk("basic_outs",  {24'd0, outs}, 32'd4);
    chk("basic_rows",  rows_req, 32'd4);
    chk("basic_sb",    32'(sb.size()), 32'd0);
    chk("basic_hscnt", 32'(hs_cnt), 32'd4);
    chk("basic_b2b",   32'(hs_cyc[3] - hs_cyc[0]), 32'd3);

    // Credit limit: stall after MAXO requests, one completion frees exactly one more
    do_start(32'd200, 32'd10, 16'd0);
    tick(6);
    chk("credit_hs",     32'(hs_cnt), 32'd4);
    chk("credit_tvalid", {31'd0, req_if.AXIS_REQ_TVALID}, 32'd0);
    chk("credit_outs",   {24'd0, outs}, 32'd4);
    row_complete = 1'b1;
    tick(1);
    row_complete = 1'b0;
    tick(3);
    chk("credit1_hs",     32'(hs_cnt), 32'd5);
    chk("credit1_tvalid", {31'd0, req_if.AXIS_REQ_TVALID}, 32'd0);
    chk("credit1_outs",   {24'd0, outs}, 32'd4);
    chk("credit1_rows",   rows_req, 32'd5);

    // Completion then completion+handshake together at outstanding 3
    row_complete = 1'b1;
    tick(2);
    row_complete = 1'b0;
    req_if.AXIS_REQ_TREADY = 1'b0;
    chk("simul_outs", {24'd0, outs}, 32'd3);
    chk("simul_rows", rows_req, 32'd6);

    // Backpressure: TVALID held, TDATA stable
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("bp_tvalid", {31'd0, req_if.AXIS_REQ_TVALID}, 32'd1);
      chk("bp_tdata",  req_if.AXIS_REQ_TDATA, 32'd206);
    end

    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    req_if.AXIS_REQ_TREADY = 1'b1;
    sb.delete();
    chk("abort1_idle",   {31'd0, idle}, 32'd1);
    chk("abort1_tvalid", {31'd0, req_if.AXIS_REQ_TVALID}, 32'd0);
    chk("abort1_rows",   rows_req, 32'd6);
    chk("abort1_outs",   {24'd0, outs}, 32'd3);

    // Completions in IDLE floor at zero
    row_complete = 1'b1;
    tick(5);
    row_complete = 1'b0;
    chk("floor_outs", {24'd0, outs}, 32'd0);

    // Zero-length start is ignored
    do_start(32'h55, 32'd0, 16'd0);
    tick(1);
    chk("zero_idle",   {31'd0, idle}, 32'd1);
    chk("zero_tvalid", {31'd0, req_if.AXIS_REQ_TVALID}, 32'd0);

    // Abort after 2 of 8 with underflows counted, then an underflow in IDLE
    do_start(32'd300, 32'd8, 16'd0);
    underflow = 1'b1;
    tick(2);
    underflow = 1'b0;
    abort = 1'b1;
    req_if.AXIS_REQ_TREADY = 1'b0;
    tick(1);
    abort = 1'b0;
    req_if.AXIS_REQ_TREADY = 1'b1;
    sb.delete();
    chk("abort2_idle",   {31'd0, idle}, 32'd1);
    chk("abort2_tvalid", {31'd0, req_if.AXIS_REQ_TVALID}, 32'd0);
    chk("abort2_rows",   rows_req, 32'd2);
    chk("abort2_outs",   {24'd0, outs}, 32'd2);
    chk("abort2_ufc",    {16'd0, ufc}, 32'd2);
    underflow = 1'b1;
    tick(1);
    underflow = 1'b0;
    chk("idle_ufc", {16'd0, ufc}, 32'd3);

    // Restart clears counters; row index wraps modulo 2^32
    do_start(32'hFFFF_FFFE, 32'd3, 16'd0);
    @(negedge clk);
    chk("clr_rows", rows_req, 32'd0);
    chk("clr_outs", {24'd0, outs}, 32'd0);
    chk("clr_ufc",  {16'd0, ufc}, 32'd0);
    wait_idle(20);
    chk("wrap_rows", rows_req, 32'd3);
    chk("wrap_sb",   32'(sb.size()), 32'd0);
    tick(1);

    // Pacing, with a start pulse mid-dataset that must be ignored
    do_start(32'd500, 32'd3, 16'd3);
    first_row  = 32'd900;
    total_rows = 32'd5;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_idle(60);
    chk("pace_hs",   32'(hs_cnt), 32'd3);
    chk("pace_rows", rows_req, 32'd3);
    chk("pace_gap1", 32'(hs_cyc[1] - hs_cyc[0]), 32'(EXP_GAP + 1));
    chk("pace_gap2", 32'(hs_cyc[2] - hs_cyc[1]), 32'(EXP_GAP + 1));
    tick(1);

    // Asynchronous reset mid-transfer
    do_start(32'd600, 32'd8, 16'd0);
    tick(1);
    underflow = 1'b1;
    tick(1);
    underflow = 1'b0;
    chk("prerst_rows", rows_req, 32'd2);
    chk("prerst_ufc",  {16'd0, ufc}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_idle",   {31'd0, idle}, 32'd1);
    chk("arst_tvalid", {31'd0, req_if.AXIS_REQ_TVALID}, 32'd0);
    chk("arst_tdata",  req_if.AXIS_REQ_TDATA, 32'd0);
    chk("arst_rows",   rows_req, 32'd0);
    chk("arst_outs",   {24'd0, outs}, 32'd0);
    chk("arst_ufc",    {16'd0, ufc}, 32'd0);
    sb.delete();
    tick(2);
    reset = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
